// File: rtl/serial_subtractor_fsm_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// master: the controller launching operations; slave: the subtractor itself.
interface serial_subtractor_fsm_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start,
    output a,
    output b,
    output bin,
    input  busy,
    input  done,
    input  diff,
    input  bout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  bin,
    output busy,
    output done,
    output diff,
    output bout
  );
endinterface

// File: rtl/serial_subtractor_fsm.sv
// Bit-serial a - b - bin, one full-subtractor step per clock, LSB first.
// diff/bout update only on the edge entering DONE and are held otherwise.
module serial_subtractor_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  serial_subtractor_fsm_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             bw;
  logic [CntW-1:0]  cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  logic             d_bit;
  logic             bw_nxt;
  logic [WIDTH-1:0] sd_nxt;

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  always_comb begin
    d_bit  = sa[0] ^ sb[0] ^ bw;
    bw_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
    sd_nxt = sd >> 1;
    sd_nxt[WIDTH-1] = d_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        // DONE accepts start exactly like IDLE, giving back-to-back operation.
        StIdle, StDone: begin
          done <= 1'b0;
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            bw    <= bus.bin;
            sd    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StShift;
          end else begin
            state <= StIdle;
          end
        end
        StShift: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_nxt;
          bw  <= bw_nxt;
          cnt <= cnt + CntW'(1);
          if (cnt == CntLast) begin
            diff  <= sd_nxt;
            bout  <= bw_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff;
  assign bus.bout = bout;

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Directed and randomised checks of the serial subtractor at WIDTH 1, 8 and 16.
module tb_serial_subtractor_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  serial_subtractor_fsm_if #(.WIDTH(1))  if1 ();
  serial_subtractor_fsm_if #(.WIDTH(8))  if8 ();
  serial_subtractor_fsm_if #(.WIDTH(16)) if16 ();

  serial_subtractor_fsm #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_subtractor_fsm #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor_fsm #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic st);
    case (w)
      1: begin if1.a = a[0]; if1.b = b[0]; if1.bin = bin; if1.start = st; end
      8: begin if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bin; if8.start = st; end
      default: begin if16.a = a; if16.b = b; if16.bin = bin; if16.start = st; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      1: return if1.done;
      8: return if8.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1: return if1.busy;
      8: return if8.busy;
      default: return if16.busy;
    endcase
  endfunction

  function automatic logic get_bout(input int w);
    case (w)
      1: return if1.bout;
      8: return if8.bout;
      default: return if16.bout;
    endcase
  endfunction

  function automatic logic [15:0] get_diff(input int w);
    case (w)
      1: return {15'b0, if1.diff};
      8: return {8'b0, if8.diff};
      default: return if16.diff;
    endcase
  endfunction

  // Launch one operation and wait (bounded) for done; lat is cycles from accept to done,
  // -1 on timeout. held reports whether diff/bout stayed put until done.
  task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, output int lat, output logic [15:0] d,
                       output logic bo, output int busy_n, output bit held);
    logic [15:0] d0;
    logic        b0;
    d0 = get_diff(w);
    b0 = get_bout(w);
    set_in(w, a, b, bin, 1'b1);
    tick();
    set_in(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    lat = 1;
    busy_n = 0;
    held = 1'b1;
    while (!get_done(w) && lat <= 40) begin
      if (get_busy(w)) busy_n++;
      if (get_diff(w) !== d0 || get_bout(w) !== b0) held = 1'b0;
      tick();
      lat++;
    end
    if (lat > 40) lat = -1;
    d  = get_diff(w);
    bo = get_bout(w);
  endtask

  task automatic test_reset();
    set_in(8, 16'h5A, 16'h3C, 1'b0, 1'b1);
    set_in(1, 16'h0, 16'h0, 1'b0, 1'b0);
    set_in(16, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) tick();
    n_tests++;
    if (if8.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_start_ignored: got %b want 0", if8.busy);
    end
    n_tests++;
    if (if8.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", if8.done);
    end
    n_tests++;
    if (if8.diff !== 8'h00) begin
      n_fail++; $display("FAIL reset_diff: got %h want 00", if8.diff);
    end
    n_tests++;
    if (if8.bout !== 1'b0) begin
      n_fail++; $display("FAIL reset_bout: got %b want 0", if8.bout);
    end
    if8.start = 1'b0;
    rst = 1'b0;
    tick();
    n_tests++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", if8.busy, if8.done);
    end
  endtask

  task automatic test_basic();
    int lat, bn; logic [15:0] d; logic bo; bit held;
    do_op(8, 16'h5A, 16'h3C, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 9 || bn != 8) begin
      n_fail++; $display("FAIL basic_latency: got lat=%0d busy=%0d want 9 8", lat, bn);
    end
    n_tests++;
    if (d !== 16'h1E || bo !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got %h/%b want 1e/0", d, bo);
    end
    n_tests++;
    if (if8.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", if8.busy);
    end
    tick();
    n_tests++;
    if (if8.done !== 1'b0 || if8.diff !== 8'h1E) begin
      n_fail++; $display("FAIL basic_pulse_hold: got done=%b diff=%h want 0 1e",
                         if8.done, if8.diff);
    end
  endtask

  task automatic test_borrow();
    int lat, bn; logic [15:0] d; logic bo; bit held;
    do_op(8, 16'h10, 16'h20, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 9 || d !== 16'hF0 || bo !== 1'b1) begin
      n_fail++; $display("FAIL borrow_underflow: got lat=%0d %h/%b want 9 f0/1", lat, d, bo);
    end
    do_op(8, 16'h00, 16'h00, 1'b1, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 9 || d !== 16'hFF || bo !== 1'b1) begin
      n_fail++; $display("FAIL borrow_bin_only: got lat=%0d %h/%b want 9 ff/1", lat, d, bo);
    end
    tick();
  endtask

  task automatic test_widths();
    int lat, bn; logic [15:0] d; logic bo; bit held;
    do_op(1, 16'h0, 16'h1, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 2 || bn != 1 || d !== 16'h1 || bo !== 1'b1) begin
      n_fail++; $display("FAIL w1_0m1: got lat=%0d busy=%0d %h/%b want 2 1 1/1", lat, bn, d, bo);
    end
    do_op(1, 16'h1, 16'h0, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 2 || d !== 16'h1 || bo !== 1'b0) begin
      n_fail++; $display("FAIL w1_1m0: got lat=%0d %h/%b want 2 1/0", lat, d, bo);
    end
    do_op(16, 16'h0000, 16'h0001, 1'b1, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 17 || d !== 16'hFFFE || bo !== 1'b1) begin
      n_fail++; $display("FAIL w16_wrap: got lat=%0d %h/%b want 17 fffe/1", lat, d, bo);
    end
    do_op(16, 16'h1234, 16'h0034, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 17 || d !== 16'h1200 || bo !== 1'b0) begin
      n_fail++; $display("FAIL w16_plain: got lat=%0d %h/%b want 17 1200/0", lat, d, bo);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int lat;
    set_in(8, 16'h5A, 16'h3C, 1'b0, 1'b1);
    tick();
    lat = 1;
    while (!if8.done && lat <= 40) begin
      if (lat == 3) set_in(8, 16'hFF, 16'h01, 1'b0, 1'b1);
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 9 || if8.diff !== 8'h1E || if8.bout !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_first: got lat=%0d %h/%b want 9 1e/0",
                         lat, if8.diff, if8.bout);
    end
    // start is still high in DONE, so the FF/01 operands launch the next operation.
    tick();
    if8.start = 1'b0;
    lat = 1;
    while (!if8.done && lat <= 40) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 9 || if8.diff !== 8'hFE || if8.bout !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_second: got lat=%0d %h/%b want 9 fe/0",
                         lat, if8.diff, if8.bout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic [15:0] d; logic bo; bit held;
    do_op(8, 16'h5A, 16'h3C, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 9 || d !== 16'h1E) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d %h want 9 1e", lat, d);
    end
    do_op(8, 16'h80, 16'h01, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 9 || bn != 8 || !held) begin
      n_fail++; $display("FAIL b2b_timing_hold: got lat=%0d busy=%0d held=%0d want 9 8 1",
                         lat, bn, held);
    end
    n_tests++;
    if (d !== 16'h7F || bo !== 1'b0) begin
      n_fail++; $display("FAIL b2b_result: got %h/%b want 7f/0", d, bo);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int lat, bn; logic [15:0] d; logic bo; bit held; bit saw_done;
    set_in(8, 16'h5A, 16'h3C, 1'b0, 1'b1);
    tick();
    set_in(8, 16'h00, 16'h00, 1'b0, 1'b0);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.diff !== 8'h00 || if8.bout !== 1'b0) begin
      n_fail++; $display("FAIL midshift_async: got busy=%b done=%b diff=%h bout=%b want 0 0 00 0",
                         if8.busy, if8.done, if8.diff, if8.bout);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (if8.done || if8.busy) saw_done = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_done || if8.diff !== 8'h00) begin
      n_fail++; $display("FAIL midshift_abort: got activity=%0d diff=%h want 0 00",
                         saw_done, if8.diff);
    end
    do_op(8, 16'h10, 16'h20, 1'b0, lat, d, bo, bn, held);
    n_tests++;
    if (lat != 9 || d !== 16'hF0 || bo !== 1'b1) begin
      n_fail++; $display("FAIL midshift_restart: got lat=%0d %h/%b want 9 f0/1", lat, d, bo);
    end
    tick();
  endtask

  task automatic test_random(input int w, input int n);
    int lat, bn, r; logic [15:0] d, a, b, mask, exp_d; logic bo, bin, exp_b; bit held;
    mask = (w == 16) ? 16'hFFFF : 16'((1 << w) - 1);
    for (int i = 0; i < n; i++) begin
      a   = 16'($urandom) & mask;
      b   = 16'($urandom) & mask;
      bin = 1'($urandom);
      r   = int'(a) - int'(b) - int'(bin);
      exp_d = 16'(r) & mask;
      exp_b = (r < 0);
      do_op(w, a, b, bin, lat, d, bo, bn, held);
      n_tests++;
      if (lat != w + 1 || d !== exp_d || bo !== exp_b) begin
        n_fail++; $display("FAIL random_w%0d: %h-%h-%b got lat=%0d %h/%b want %0d %h/%b",
                           w, a, b, bin, lat, d, bo, w + 1, exp_d, exp_b);
      end
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_widths();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_shift();
    test_random(1, 150);
    test_random(8, 150);
    test_random(16, 150);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
